// File: rtl/reg_file_32x32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_32x32_pkg
//  Description : Datapath constants shared by the control unit, the 3:1
//                write-destination mux selects and the register file.
//                REG_ADDR_W / DATA_W : register address and data widths
//                REG_ZERO / REG_RA   : hard-wired zero register and the
//                                      return-address register ($31)
//  Revision    : 1.0  initial release
// ============================================================================
package reg_file_32x32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_32x32_pkg
`default_nettype wire

// File: rtl/reg_file_32x32_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_32x32_if
//  Description : Write / read / debug bus of the register file.
//                master : drives we, waddr, wdata, raddr1, raddr2, dbg_addr
//                         and observes rdata1, rdata2, dbg_data, wr_count
//                slave  : the register file side of the same signals
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_file_32x32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [31:0]       wr_count;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count
    );

endinterface : reg_file_32x32_if
`default_nettype wire

// File: rtl/reg_file_32x32_rd_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_32x32_rd_port
//  Description : Combinational output selection for one read port:
//                $0 forced to zero, optional write-first bypass, otherwise
//                the stored array word.
//                i_raddr : read address        i_word  : array[i_raddr]
//                i_we    : qualified write enable (includes reset state)
//                i_waddr : write address       i_wdata : write data
//                o_rdata : read data
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_32x32_rd_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  wire logic [ADDR_W-1:0] i_raddr,
    input  wire logic [DATA_W-1:0] i_word,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output      logic [DATA_W-1:0] o_rdata
);
    import reg_file_32x32_pkg::*;

    localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(REG_ZERO);

    logic w_bypass_hit;

    // A hit needs a non-zero read address; since raddr == waddr, that also
    // guarantees the write itself targets a real register.
    assign w_bypass_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

    always_comb begin
        o_rdata = i_word;
        if (i_raddr == c_ZERO) begin
            o_rdata = '0;
        end else if (w_bypass_hit) begin
            o_rdata = i_wdata;
        end
    end

endmodule : reg_file_32x32_rd_port
`default_nettype wire

// File: rtl/reg_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_32x32
//  Description : 32 x 32-bit general-purpose register file of the
//                single-cycle datapath. Two operand read ports plus a debug
//                read port, all combinational; one synchronous write port;
//                accepted-write counter.
//                clk   : rising-edge clock
//                rst_n : synchronous active-low reset
//                bus   : slave side of reg_file_32x32_if
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input wire logic         clk,
    input wire logic         rst_n,
    reg_file_32x32_if.slave  bus
);
    import reg_file_32x32_pkg::*;

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [31:0]       r_wr_count;

    logic              w_we_q;
    logic              w_wr_accept;

    // Write enable qualified by reset: reset overrides a simultaneous write
    // both for storage and for the bypass path.
    assign w_we_q      = rst_n && bus.we;
    assign w_wr_accept = w_we_q && (bus.waddr != c_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_accept) begin
            r_regs[bus.waddr] <= bus.wdata;
            r_wr_count        <= r_wr_count + 32'd1;
        end
    end

    assign bus.wr_count = r_wr_count;

    reg_file_32x32_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_port1 (
        .i_raddr (bus.raddr1),
        .i_word  (r_regs[bus.raddr1]),
        .i_we    (w_we_q),
        .i_waddr (bus.waddr),
        .i_wdata (bus.wdata),
        .o_rdata (bus.rdata1)
    );

    reg_file_32x32_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_port2 (
        .i_raddr (bus.raddr2),
        .i_word  (r_regs[bus.raddr2]),
        .i_we    (w_we_q),
        .i_waddr (bus.waddr),
        .i_wdata (bus.wdata),
        .o_rdata (bus.rdata2)
    );

    reg_file_32x32_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd_dbg (
        .i_raddr (bus.dbg_addr),
        .i_word  (r_regs[bus.dbg_addr]),
        .i_we    (w_we_q),
        .i_waddr (bus.waddr),
        .i_wdata (bus.wdata),
        .o_rdata (bus.dbg_data)
    );

endmodule : reg_file_32x32
`default_nettype wire

// File: tb/tb_reg_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_32x32
//  Description : Self-checking bench for reg_file_32x32. Two instances
//                (BYPASS=1 and BYPASS=0) receive identical stimulus; a
//                reference model produces expected values that are queued
//                and later popped against the observed DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_32x32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    reg_file_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        d_we;
    logic [4:0]  d_wa;
    logic [31:0] d_wd;
    logic [4:0]  d_r1, d_r2, d_dbg;

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0)                              return 32'd0;
        if (byp && rst_n && d_we && d_wa == a)      return d_wd;
        return m_regs[a];
    endfunction

    task automatic drive_wr(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        d_we = we; d_wa = wa; d_wd = wd;
        bus_a.we = we; bus_a.waddr = wa; bus_a.wdata = wd;
        bus_b.we = we; bus_b.waddr = wa; bus_b.wdata = wd;
    endtask

    task automatic drive_rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
        d_r1 = a1; d_r2 = a2; d_dbg = dbg;
        bus_a.raddr1 = a1; bus_a.raddr2 = a2; bus_a.dbg_addr = dbg;
        bus_b.raddr1 = a1; bus_b.raddr2 = a2; bus_b.dbg_addr = dbg;
    endtask

    // One rising edge; the model commits using the bench's own driven values.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (d_we && d_wa != 5'd0) begin
            m_regs[d_wa] = d_wd;
            m_cnt        = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] wa, input logic [31:0] wd);
        drive_wr(1'b1, wa, wd);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
    endtask

    // Queue expected values from the model and capture the DUT outputs.
    task automatic snap(input string tag);
        #1;
        sb.push_back('{{tag, " A.rdata1"},   m_read(d_r1, 1'b1)});
        sb.push_back('{{tag, " A.rdata2"},   m_read(d_r2, 1'b1)});
        sb.push_back('{{tag, " A.dbg_data"}, m_read(d_dbg, 1'b1)});
        sb.push_back('{{tag, " A.wr_count"}, m_cnt});
        sb.push_back('{{tag, " B.rdata1"},   m_read(d_r1, 1'b0)});
        sb.push_back('{{tag, " B.rdata2"},   m_read(d_r2, 1'b0)});
        sb.push_back('{{tag, " B.dbg_data"}, m_read(d_dbg, 1'b0)});
        sb.push_back('{{tag, " B.wr_count"}, m_cnt});
        obs.push_back(bus_a.rdata1);  obs.push_back(bus_a.rdata2);
        obs.push_back(bus_a.dbg_data); obs.push_back(bus_a.wr_count);
        obs.push_back(bus_b.rdata1);  obs.push_back(bus_b.rdata2);
        obs.push_back(bus_b.dbg_data); obs.push_back(bus_b.wr_count);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t e; logic [31:0] o;
        rst_n = 1'b0;
        drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        drive_rd(5'd5, 5'd5, 5'd0);
        tick();
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            drive_rd(5'(a), 5'(31 - a), 5'(a));
            snap($sformatf("reset r%0d", a));
        end
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_basic_rw();
        exp_t e; logic [31:0] o;
        @(negedge clk);
        do_write(5'd8, 32'h1234_5678);
        do_write(5'd31, 32'h8765_4321);
        drive_rd(5'd8, 5'd31, 5'd8);
        snap("basic");
        if (m_cnt !== 32'd2) $display("bench model count off: %0d", m_cnt);
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_zero_protect();
        exp_t e; logic [31:0] o;
        @(negedge clk);
        drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive_rd(5'd0, 5'd0, 5'd0);
        snap("zero same-cycle");
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        snap("zero next-cycle");
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        exp_t e; logic [31:0] o;
        @(negedge clk);
        do_write(5'd9, 32'h0000_0001);
        drive_wr(1'b1, 5'd9, 32'h0000_0002);
        drive_rd(5'd9, 5'd9, 5'd9);
        snap("bypass before-edge");
        drive_rd(5'd9, 5'd8, 5'd31);
        snap("bypass one-port");
        drive_rd(5'd9, 5'd9, 5'd9);
        tick();
        drive_wr(1'b0, 5'd0, 32'd0);
        snap("bypass after-edge");
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [31:0] o;
        @(negedge clk);
        do_write(5'd3, 32'hA5A5_A5A5);
        drive_rd(5'd3, 5'd4, 5'd3);
        snap("pre-reset");
        rst_n = 1'b0;
        drive_wr(1'b1, 5'd4, 32'h5A5A_5A5A);
        snap("reset+write before-edge");
        tick();
        rst_n = 1'b1;
        drive_wr(1'b0, 5'd0, 32'd0);
        snap("reset+write after-edge");
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_counter_wrap();
        exp_t e; logic [31:0] o;
        @(negedge clk);
        force dut_a.r_wr_count = 32'hFFFF_FFFF;
        force dut_b.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut_a.r_wr_count;
        release dut_b.r_wr_count;
        m_cnt = 32'hFFFF_FFFF;
        drive_rd(5'd1, 5'd1, 5'd1);
        snap("wrap preload");
        do_write(5'd1, 32'h0000_0011);
        snap("wrap after write");
        do_write(5'd1, 32'h0000_0011);
        snap("same value recount");
        while (sb.size() != 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_checks++;
            if (o !== e.exp) $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_cnt = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        drive_wr(1'b0, 5'd0, 32'd0);
        drive_rd(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_zero_protect();
        test_bypass();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file_32x32
`default_nettype wire

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- General-purpose register file of the single-cycle MIPS-style datapath.
- Sits directly downstream of the 5-bit 3:1 write-destination mux, which selects rt, rd or 31.
- Its two read ports feed the ALU operand path, including the 32-bit 2:1 ALUSrc mux.
- Holds 32 x 32-bit registers; $0 is hard-wired to zero. Adds a debug read port and an accepted-write counter for bench visibility.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width (2**ADDR_W registers)
BYPASS, 1, 1 = a read of the address being written this cycle returns wdata (write-first); 0 = returns the stored (old) value

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
we  in  1  write enable (RegWrite from control)
waddr  in  ADDR_W  write register address (3:1 mux output)
wdata  in  DATA_W  write data (MemtoReg mux output)
raddr1  in  ADDR_W  read port 1 address (rs)
raddr2  in  ADDR_W  read port 2 address (rt)
rdata1  out  DATA_W  read port 1 data
rdata2  out  DATA_W  read port 2 data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data (same rules as read ports)
wr_count  out  32  number of accepted writes since reset

Behaviour:
- One clock (clk); reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset:
  - On any rising edge with rst_n=0, all 32 registers clear to 0 and wr_count clears to 0.
  - we is ignored on that edge.
  - After the reset edge, all read outputs show 0.
  - Reset asserted mid-program overrides a simultaneous write.
- Read timing:
  - rdata1, rdata2 and dbg_data are combinational in their address: zero-cycle latency.
  - Required for single-cycle operation.
- Write timing:
  - Write is accepted on a rising edge with rst_n=1, we=1 and waddr!=0: regs[waddr] <= wdata.
  - The new value is visible through the array from the next cycle.
- $0:
  - Reads of address 0 always return 0, regardless of the array, BYPASS or we.
  - Writes to address 0 are discarded and do not increment wr_count.
- Bypass:
  - With BYPASS=1, a read port whose address equals waddr while we=1, rst_n=1 and waddr!=0 returns wdata in the same cycle.
  - With BYPASS=0 it returns the stored value.
  - The rule applies independently to all three read ports; both ports may hit simultaneously.
- Same-address reads: raddr1==raddr2 returns identical data on both ports.
- wr_count:
  - Increments by 1 on each accepted write.
  - Wraps 32'hFFFF_FFFF -> 0 with no flag.
  - Writing the same value again still counts.
- Writes and reads are unsigned bit copies; no width conversion.
- X/undefined addresses are not required to be handled.

Decomposition:
- Shared package (datapath constants used by the control unit, the 3:1 mux selects and this block):
  - REG_ADDR_W=5, DATA_W=32
  - REG_ZERO=5'd0, REG_RA=5'd31
- Natural sub-module: reg_file_rd_port, instantiated three times for rdata1, rdata2 and dbg_data.
  - Inputs: raddr, the selected array word, we, waddr, wdata.
  - Function: the combinational zero-register and bypass selection for one read port.
- Storage array, write logic and wr_count stay in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n=0 for 2 edges with we=1, waddr=5, wdata=32'hDEAD_BEEF.
   - Required: all 32 registers read 0 via dbg_addr sweep; wr_count=0.
2. Basic write/read:
   - Stimulus: write 32'h1234_5678 to $8 and 32'h8765_4321 to $31, then raddr1=8, raddr2=31.
   - Required: rdata1=32'h1234_5678, rdata2=32'h8765_4321; wr_count=2.
3. $0 protection:
   - Stimulus: we=1, waddr=0, wdata=32'hFFFF_FFFF; read raddr1=0 in the same and next cycle.
   - Required: rdata1=0 in both cycles; wr_count unchanged.
4. Bypass, BYPASS=1:
   - Stimulus: $9 holds 32'h0000_0001; in one cycle set we=1, waddr=9, wdata=32'h0000_0002, raddr1=raddr2=9.
   - Required: both ports read 32'h0000_0002 before the edge.
   - Repeat with BYPASS=0: both ports read 32'h0000_0001 before the edge and 32'h0000_0002 after it.
5. Reset mid-operation:
   - Stimulus: after writing $3=32'hA5A5_A5A5, assert rst_n=0 on the same edge as a write to $4=32'h5A5A_5A5A.
   - Required: $3=0, $4=0, wr_count=0.
6. Counter wrap:
   - Stimulus: force wr_count to 32'hFFFF_FFFF via back-door, then perform one accepted write to $1.
   - Required: wr_count=0.
